// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPO/GPI command interface.
// Used by the command master, the command decoder and the benches.
package gpio_cmd_pkg;

  localparam int CMD_MSB  = 31;
  localparam int CMD_LSB  = 24;
  localparam int ENB_BIT  = 23;
  localparam int DATA_MSB = 22;

  typedef enum logic [7:0] {
    RESET        = 8'd0,
    EN_TX        = 8'd1,
    EN_RX        = 8'd2,
    PH_SEL       = 8'd3,
    RUN_BER      = 8'd4,
    STOP_BER     = 8'd5,
    RD_BER_SAMP  = 8'd6,
    RD_BER_ERR   = 8'd7,
    RD_BER_HIGH  = 8'd8,
    RUN_MEM      = 8'd9,
    RD_MEM       = 8'd10,
    RD_MEM_PTR   = 8'd11,
    IS_MEM_FULL  = 8'd12
  } gpio_cmd_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

endpackage

// File: rtl/gpio_cmd_master.sv
// Command initiator: drives one GPO command word with an enable
// pulse, waits for the decoder to settle, returns the GPI word.
module gpio_cmd_master
  import gpio_cmd_pkg::*;
#(
  parameter int NB_GPIOS     = 32,
  parameter int NB_CMD       = 8,
  parameter int NB_DATA      = 23,
  parameter int ENB_HIGH_CYC = 2,
  parameter int SETTLE_CYC   = 4
) (
  input  logic                clk100,
  input  logic                i_resetn,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [NB_CMD-1:0]   i_req_cmd,
  input  logic [NB_DATA-1:0]  i_req_data,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [NB_CMD-1:0]   o_rsp_cmd,
  output logic [NB_GPIOS-1:0] o_rsp_data,
  output logic [NB_GPIOS-1:0] o_gpo,
  input  logic [NB_GPIOS-1:0] i_gpi,
  output logic                o_busy
);

  localparam int ENB = NB_DATA;
  localparam int MAXC =
    (ENB_HIGH_CYC > SETTLE_CYC) ? ENB_HIGH_CYC : SETTLE_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] H_LD = CW'(ENB_HIGH_CYC - 1);
  localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYC - 1);

  logic [2:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [NB_GPIOS-1:0] r_gpo;
  logic                r_rsp_valid;
  logic [NB_CMD-1:0]   r_rsp_cmd;
  logic [NB_GPIOS-1:0] r_rsp_data;
  logic                w_cnt_zero;

  assign w_cnt_zero  = (r_cnt == '0);
  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_gpo       = r_gpo;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_cmd   = r_rsp_cmd;
  assign o_rsp_data  = r_rsp_data;

  // Sequencer: setup word, enable pulse, settle, then hold response.
  always_ff @(posedge clk100 or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gpo       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_cmd   <= '0;
      r_rsp_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_gpo   <= {i_req_cmd, 1'b0, i_req_data};
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_gpo[ENB] <= 1'b1;
          r_cnt      <= H_LD;
          r_state    <= ST_STROBE;
        end
        ST_STROBE: begin
          if (w_cnt_zero) begin
            r_gpo[ENB] <= 1'b0;
            r_cnt      <= S_LD;
            r_state    <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            r_rsp_data  <= i_gpi;
            r_rsp_cmd   <= r_gpo[NB_GPIOS-1 -: NB_CMD];
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Bench for gpio_cmd_master: vector table, hand sequences and
// randomized commands against a cycle-timeline reference model.
module tb_gpio_cmd_master;
  import gpio_cmd_pkg::*;

  localparam int H = 2;
  localparam int S = 4;

  logic        clk100 = 1'b0;
  logic        i_resetn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [7:0]  i_req_cmd;
  logic [22:0] i_req_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [7:0]  o_rsp_cmd;
  logic [31:0] o_rsp_data;
  logic [31:0] o_gpo;
  logic [31:0] i_gpi;
  logic        o_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rises = 0;
  int exp_pulses = 0;
  int rise_q[$];
  logic prev_en = 1'b0;

  gpio_cmd_master #(
    .NB_GPIOS(32), .NB_CMD(8), .NB_DATA(23),
    .ENB_HIGH_CYC(H), .SETTLE_CYC(S)
  ) dut (
    .clk100(clk100), .i_resetn(i_resetn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_cmd(i_req_cmd), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_cmd(o_rsp_cmd), .o_rsp_data(o_rsp_data),
    .o_gpo(o_gpo), .i_gpi(i_gpi), .o_busy(o_busy)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc <= cyc + 1;

  // Enable-pulse monitor, sampled away from the active edge.
  always @(negedge clk100) begin
    if (o_gpo[23] && !prev_en) begin
      rises = rises + 1;
      rise_q.push_back(cyc);
    end
    prev_en = o_gpo[23];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [22:0] data;
    logic [31:0] gpi;
    int          hold;
    bit          intr;
    logic [31:0] e_set;
    logic [31:0] e_stb;
  } vec_t;

  vec_t vt[4];

  function automatic logic [31:0] word(input logic [7:0] c,
                                       input logic [22:0] d,
                                       input logic en);
    return {c, en, d};
  endfunction

  task automatic chk(input string nm, input string f, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s cyc%0d: got %h want %h", nm, f, k, act, exp);
    end
  endtask

  // One command, starting at a negedge in IDLE (cycle 0), ending at
  // the negedge of the following IDLE cycle.
  task automatic run_cmd(input logic [7:0] c, input logic [22:0] d,
                         input logic [31:0] g, input int hold,
                         input bit intr, input logic [31:0] e_set,
                         input logic [31:0] e_stb, input string nm);
    int last;
    logic [31:0] eg;
    logic ev, eb;
    chk(nm, "ready0", 0, o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_cmd   = c;
    i_req_data  = d;
    i_gpi       = ~g;
    i_rsp_ready = (hold == 0);
    exp_pulses++;
    last = H + S + 3 + hold;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk100);
      eg = (k >= 2 && k <= H + 1) ? e_stb : e_set;
      ev = (k >= H + S + 2) && (k < last);
      eb = (k < last);
      chk(nm, "gpo", k, o_gpo, eg);
      chk(nm, "rsp_valid", k, o_rsp_valid, ev);
      chk(nm, "req_ready", k, o_req_ready, !eb);
      chk(nm, "busy", k, o_busy, eb);
      if (ev) begin
        chk(nm, "rsp_data", k, o_rsp_data, g);
        chk(nm, "rsp_cmd", k, o_rsp_cmd, c);
      end
      if (k == 1) begin
        i_req_valid = intr;
        i_req_cmd   = 8'($urandom);
        i_req_data  = 23'($urandom);
      end
      if (k == H + S + 1) i_gpi = g;
      else i_gpi = $urandom;
      if (k == H + S + 2 + hold) begin
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    vt[0] = '{8'd1, 23'd1, 32'hDEADBEEF, 0, 1'b0,
              32'h01000001, 32'h01800001};
    vt[1] = '{8'd5, 23'h123456, 32'hCAFEF00D, 10, 1'b1,
              32'h05123456, 32'h05923456};
    vt[2] = '{8'hFF, 23'h7FFFFF, 32'h00000000, 0, 1'b0,
              32'hFF7FFFFF, 32'hFFFFFFFF};
    vt[3] = '{8'd12, 23'd0, 32'hFFFFFFFF, 1, 1'b1,
              32'h0C000000, 32'h0C800000};

    i_resetn    = 1'b0;
    i_req_valid = 1'b0;
    i_req_cmd   = '0;
    i_req_data  = '0;
    i_rsp_ready = 1'b0;
    i_gpi       = '0;
    repeat (3) @(negedge clk100);
    chk("reset", "gpo", 0, o_gpo, 32'h0);
    chk("reset", "req_ready", 0, o_req_ready, 1);
    chk("reset", "rsp_valid", 0, o_rsp_valid, 0);
    chk("reset", "busy", 0, o_busy, 0);
    chk("reset", "rsp_data", 0, o_rsp_data, 32'h0);
    chk("reset", "rsp_cmd", 0, o_rsp_cmd, 8'h0);
    i_resetn = 1'b1;
    @(negedge clk100);

    for (int i = 0; i < 4; i++)
      run_cmd(vt[i].cmd, vt[i].data, vt[i].gpi, vt[i].hold,
              vt[i].intr, vt[i].e_set, vt[i].e_stb,
              $sformatf("vec%0d", i));

    // Reset in the middle of the enable pulse.
    i_req_valid = 1'b1;
    i_req_cmd   = 8'd2;
    i_req_data  = 23'd5;
    exp_pulses++;
    @(negedge clk100);
    i_req_valid = 1'b0;
    @(negedge clk100);
    chk("rst_mid", "gpo_pre", 2, o_gpo, 32'h02800005);
    i_resetn = 1'b0;
    #1;
    chk("rst_mid", "gpo", 2, o_gpo, 32'h0);
    chk("rst_mid", "req_ready", 2, o_req_ready, 1);
    chk("rst_mid", "busy", 2, o_busy, 0);
    chk("rst_mid", "rsp_valid", 2, o_rsp_valid, 0);
    @(negedge clk100);
    i_resetn = 1'b1;
    @(negedge clk100);
    run_cmd(8'd3, 23'h0ABCDE, 32'h13572468, 0, 1'b0,
            word(8'd3, 23'h0ABCDE, 1'b0),
            word(8'd3, 23'h0ABCDE, 1'b1), "after_rst");

    // Back-to-back commands 0..12 with the consumer always ready.
    rise_q.delete();
    for (int c = 0; c <= 12; c++) begin
      logic [22:0] d;
      d = 23'($urandom);
      run_cmd(8'(c), d, $urandom, 0, 1'b0, word(8'(c), d, 1'b0),
              word(8'(c), d, 1'b1), $sformatf("b2b%0d", c));
    end
    chk("b2b", "pulses", 0, rise_q.size(), 13);
    if (rise_q.size() == 13)
      for (int i = 1; i < 13; i++)
        chk("b2b", "spacing", i, rise_q[i] - rise_q[i-1], 9);

    // Randomized commands, stalls and ignored requests.
    for (int n = 0; n < 20; n++) begin
      logic [7:0]  c;
      logic [22:0] d;
      c = 8'($urandom);
      d = 23'($urandom);
      run_cmd(c, d, $urandom, int'($urandom_range(0, 4)),
              1'($urandom), word(c, d, 1'b0), word(c, d, 1'b1),
              $sformatf("rnd%0d", n));
    end

    chk("all", "pulses", 0, rises, exp_pulses);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
